wf_samp_capture: RTL and testbench

- Waterfall capture stage directly downstream of the waterfall CIC pair, in the adc_clk domain.
- Takes decimated I/Q strobes, rescales each to 16 bits with rounding and saturation, and stores I/Q pairs in a single-clock RAM.
- Supports one-shot fill and continuous ring capture.
- Exposes a synchronous read port for the bus bridge, which supplies already-synchronised controls.

---
 rtl/wf_samp_capture_pkg.sv | 34 +++
 rtl/wf_round_sat.sv | 28 ++
 rtl/wf_samp_capture.sv | 138 +++++++++++++
 tb/tb_wf_samp_capture.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wf_samp_capture_pkg.sv
// Shared waterfall capture definitions: state encoding, default depth and
// the rounding-shift / saturation helpers used by the scaling lanes.
package wf_samp_capture_pkg;

  typedef enum logic [1:0] {
    WFC_IDLE = 2'd0,
    WFC_FILL = 2'd1,
    WFC_DONE = 2'd2,
    WFC_CONT = 2'd3
  } wfc_state_e;

  localparam int WFC_DEPTH_LOG2 = 10;
  localparam int WFC_DEPTH      = 1 << WFC_DEPTH_LOG2;
  localparam int WFC_LANES      = 2;  // lane 0 = I, lane 1 = Q

  // Round half up, then arithmetic right shift. Inputs up to 31 bits cannot overflow.
  function automatic logic signed [31:0] wfc_round_shift(input logic signed [31:0] x,
                                                         input logic [4:0] sh);
    logic signed [31:0] bias;
    bias = (sh == 5'd0) ? 32'sd0 : (32'sd1 <<< (sh - 5'd1));
    return (x + bias) >>> sh;
  endfunction

  function automatic logic signed [31:0] wfc_sat(input logic signed [31:0] x,
                                                 input int unsigned ow);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (ow - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (ow - 1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/wf_round_sat.sv
// One scaling lane: registered round+shift, then clamp feeding the RAM write.
module wf_round_sat import wf_samp_capture_pkg::*; #(
  parameter int IN_WIDTH  = 24,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        adc_clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [4:0]                  shift,
  input  logic signed [IN_WIDTH-1:0]  din,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        sat
);

  logic signed [31:0] s1, s2;

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n)  s1 <= '0;
    else if (en) s1 <= wfc_round_shift(32'(din), shift);
  end

  always_comb begin
    s2   = wfc_sat(s1, OUT_WIDTH);
    dout = s2[OUT_WIDTH-1:0];
    sat  = (s2 != s1);
  end

endmodule

// File: rtl/wf_samp_capture.sv
// Waterfall I/Q capture: scale to OUT_WIDTH, store pairs in RAM, one-shot or ring.
// Optional WF_CAPT_PEAK_EN adds a peak |I|/|Q| magnitude output.
module wf_samp_capture import wf_samp_capture_pkg::*; #(
  parameter int IN_WIDTH   = 24,
  parameter int OUT_WIDTH  = 16,
  parameter int DEPTH_LOG2 = WFC_DEPTH_LOG2
) (
  input  logic                  adc_clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic                  continuous,
  input  logic [4:0]            shift,
  input  logic                  in_strobe,
  input  logic [IN_WIDTH-1:0]   in_i,
  input  logic [IN_WIDTH-1:0]   in_q,
  input  logic                  rd_en,
  input  logic                  rd_sel_q,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  input  logic [DEPTH_LOG2-1:0] rd_offset,
  output logic [OUT_WIDTH-1:0]  rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic [DEPTH_LOG2-1:0] wr_ptr,
  output logic [15:0]           sat_cnt
`ifdef WF_CAPT_PEAK_EN
  ,output logic [OUT_WIDTH-1:0] peak
`endif
);

  localparam int LANES = WFC_LANES;

  wfc_state_e                           state;
  logic [4:0]                           shift_r;
  logic                                 accept, s1_vld, wr_en;
  logic [DEPTH_LOG2-1:0]                s1_addr, rd_phys;
  logic [LANES-1:0][IN_WIDTH-1:0]       lane_in;
  logic [LANES-1:0][OUT_WIDTH-1:0]      lane_out;
  logic [LANES-1:0]                     lane_sat;
  logic [LANES*OUT_WIDTH-1:0]           mem [2**DEPTH_LOG2];

  assign lane_in = {in_q, in_i};
  assign accept  = in_strobe && !arm && busy;
  // Gating with arm drops the in-flight sample so nothing stale lands after re-arm.
  assign wr_en   = s1_vld && !arm;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    wf_round_sat #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_rs (
      .adc_clk (adc_clk),
      .rst_n   (rst_n),
      .en      (accept),
      .shift   (shift_r),
      .din     (lane_in[l]),
      .dout    (lane_out[l]),
      .sat     (lane_sat[l])
    );
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WFC_IDLE;
      shift_r <= '0;
      wr_ptr  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (arm) begin
      state   <= continuous ? WFC_CONT : WFC_FILL;
      shift_r <= shift;
      wr_ptr  <= '0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else if (accept) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (state == WFC_FILL && wr_ptr == '1) begin
        state <= WFC_DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_addr <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) s1_addr <= wr_ptr;
    end
  end

  always_ff @(posedge adc_clk) begin
    if (wr_en) mem[s1_addr] <= lane_out;
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n)                                       sat_cnt <= '0;
    else if (arm)                                     sat_cnt <= '0;
    else if (wr_en && (|lane_sat) && sat_cnt != '1)   sat_cnt <= sat_cnt + 16'd1;
  end

  // Ring mode reads oldest-first, so the logical index is relative to wr_ptr.
  assign rd_phys = ((state == WFC_CONT) ? wr_ptr : '0) + rd_addr + rd_offset;

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_sel_q ? mem[rd_phys][2*OUT_WIDTH-1:OUT_WIDTH]
                                     : mem[rd_phys][OUT_WIDTH-1:0];
    end
  end

`ifdef WF_CAPT_PEAK_EN
  function automatic logic [OUT_WIDTH-1:0] mag(input logic [OUT_WIDTH-1:0] v);
    if (!v[OUT_WIDTH-1])                          return v;
    else if (v == {1'b1, {(OUT_WIDTH-1){1'b0}}})  return {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else                                          return -v;
  endfunction

  logic [OUT_WIDTH-1:0] mag_i, mag_q, mag_max;

  always_comb begin
    mag_i   = mag(lane_out[0]);
    mag_q   = mag(lane_out[1]);
    mag_max = (mag_i > mag_q) ? mag_i : mag_q;
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n)                         peak <= '0;
    else if (arm)                       peak <= '0;
    else if (wr_en && mag_max > peak)   peak <= mag_max;
  end
`endif

endmodule

// File: tb/tb_wf_samp_capture.sv
// Self-checking bench for wf_samp_capture: vector table, corner sequences, random vs model.
module tb_wf_samp_capture;
  localparam int IW = 24, OW = 16, DL = 10, DEPTH = 1024;

  logic adc_clk = 1'b0, rst_n = 1'b0, arm = 1'b0, continuous = 1'b0;
  logic [4:0] shift = '0;
  logic in_strobe = 1'b0;
  logic [IW-1:0] in_i = '0, in_q = '0;
  logic rd_en = 1'b0, rd_sel_q = 1'b0;
  logic [DL-1:0] rd_addr = '0, rd_offset = '0;
  logic [OW-1:0] rd_data;
  logic rd_valid, busy, done;
  logic [DL-1:0] wr_ptr;
  logic [15:0] sat_cnt;
`ifdef WF_CAPT_PEAK_EN
  logic [OW-1:0] peak;
`endif

  wf_samp_capture #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH_LOG2(DL)) dut (
    .adc_clk(adc_clk), .rst_n(rst_n), .arm(arm), .continuous(continuous), .shift(shift),
    .in_strobe(in_strobe), .in_i(in_i), .in_q(in_q), .rd_en(rd_en), .rd_sel_q(rd_sel_q),
    .rd_addr(rd_addr), .rd_offset(rd_offset), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .wr_ptr(wr_ptr), .sat_cnt(sat_cnt)
`ifdef WF_CAPT_PEAK_EN
    , .peak(peak)
`endif
  );

  always #5 adc_clk = ~adc_clk;

  int checks = 0, failures = 0;

  typedef struct {
    int sh; int vi; int vq; int ei; int eq; int esat; string nm;
  } vec_t;
  vec_t vecs[$];

  int mi[DEPTH], mq[DEPTH];

  // Reference: value / 2^sh rounded half up, then clamp to the 16-bit range.
  function automatic int ref_scale(int x, int sh);
    real r;
    if (sh == 0) return x;
    r = $floor(x / (2.0 ** sh) + 0.5);
    return int'(r);
  endfunction

  function automatic int ref_clamp(int y);
    if (y > 32767)  return 32767;
    if (y < -32768) return -32768;
    return y;
  endfunction

  function automatic int rand24();
    int v;
    v = int'($urandom_range(0, 32'hFFFFFF)) - 32'sh800000;
    if ($urandom_range(0, 1) == 1) v = v / (1 << $urandom_range(0, 14));
    return v;
  endfunction

  task automatic tick();
    @(posedge adc_clk); #1;
  endtask

  task automatic settle();
    repeat (3) tick();
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", nm, got, exp);
    end
  endtask

  task automatic arm_cap(input logic c, input int sh);
    arm = 1'b1; continuous = c; shift = sh[4:0];
    tick();
    arm = 1'b0;
  endtask

  task automatic strobe(input int vi, input int vq);
    in_strobe = 1'b1; in_i = vi[IW-1:0]; in_q = vq[IW-1:0];
    tick();
    in_strobe = 1'b0;
  endtask

  task automatic chk_rd(input string nm, input logic sel, input int a, input int off, input int e);
    rd_en = 1'b1; rd_sel_q = sel; rd_addr = a[DL-1:0]; rd_offset = off[DL-1:0];
    tick();
    rd_en = 1'b0;
    check({nm, "_valid"}, 32'(rd_valid), 32'd1);
    check(nm, 32'(rd_data), e & 32'hFFFF);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int sh, n, vi, vq, a, off, phys, exp_sat;

    vecs.push_back('{4, 'h18, -'h18, 2, -1, 0, "rnd_half_up"});
    vecs.push_back('{4, 'h17, 'h8, 1, 1, 0, "rnd_below_half"});
    vecs.push_back('{4, 'h7, -'h9, 0, -1, 0, "rnd_small"});
    vecs.push_back('{1, 3, -3, 2, -1, 0, "rnd_shift1"});
    vecs.push_back('{0, 'h7FFFFF, 0, 'h7FFF, 0, 1, "sat_pos_sh0"});
    vecs.push_back('{0, 0, -'h800000, 0, -32768, 1, "sat_neg_sh0"});
    vecs.push_back('{8, 'h7FFF80, -'h800000, 'h7FFF, -32768, 1, "sat_round_over"});
    vecs.push_back('{8, 'h7FFF7F, -'h7FFF81, 'h7FFF, -32768, 0, "edge_no_sat"});

    // reset state
    repeat (3) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wr_ptr", 32'(wr_ptr), 0);
    check("rst_sat_cnt", 32'(sat_cnt), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    rst_n = 1'b1;
    tick();

    // one-shot fill, shift 8
    arm_cap(1'b0, 8);
    check("fill_busy", 32'(busy), 1);
    for (int k = 0; k < DEPTH; k++) strobe(k * 256, -k * 256);
    check("fill_done", 32'(done), 1);
    check("fill_not_busy", 32'(busy), 0);
    check("fill_wr_ptr", 32'(wr_ptr), 0);
    settle();
    rd_en = 1'b1; rd_sel_q = 1'b0; rd_addr = 10'd5; rd_offset = '0;
    check("lat_pre", 32'(rd_valid), 0);
    tick();
    rd_en = 1'b0;
    check("lat_valid", 32'(rd_valid), 1);
    check("lat_data", 32'(rd_data), 5);
    tick();
    check("lat_drop", 32'(rd_valid), 0);
    check("lat_hold", 32'(rd_data), 5);
    chk_rd("os_i0", 0, 0, 0, 0);
    chk_rd("os_i1", 0, 1, 0, 1);
    chk_rd("os_q511", 1, 511, 0, -511);
    chk_rd("os_i1023", 0, 1023, 0, 1023);
    chk_rd("os_q1023", 1, 1023, 0, -1023);
    strobe('h7FFF00, 'h7FFF00);
    settle();
    chk_rd("os_extra_ignored", 0, 0, 0, 0);
    check("os_extra_wr_ptr", 32'(wr_ptr), 0);
    check("os_extra_done", 32'(done), 1);

    // rounding / saturation table
    foreach (vecs[v]) begin
      arm_cap(1'b0, vecs[v].sh);
      strobe(vecs[v].vi, vecs[v].vq);
      settle();
      chk_rd({vecs[v].nm, "_i"}, 0, 0, 0, vecs[v].ei);
      chk_rd({vecs[v].nm, "_q"}, 1, 0, 0, vecs[v].eq);
      check({vecs[v].nm, "_sat"}, 32'(sat_cnt), vecs[v].esat);
    end

    // accumulating saturation count, once per pair
    arm_cap(1'b0, 0);
    strobe('h7FFFFF, 0);
    settle();
    check("satseq_1", 32'(sat_cnt), 1);
    strobe(0, -'h800000);
    settle();
    check("satseq_2", 32'(sat_cnt), 2);
    chk_rd("satseq_q", 1, 1, 0, 'h8000);
    strobe('h7FFFFF, -'h800000);
    settle();
    check("satseq_pair", 32'(sat_cnt), 3);

    // continuous ring
    arm_cap(1'b1, 0);
    for (int k = 0; k < 1030; k++) strobe(k, -k);
    settle();
    check("cont_wr_ptr", 32'(wr_ptr), 6);
    check("cont_busy", 32'(busy), 1);
    check("cont_done", 32'(done), 0);
    chk_rd("cont_oldest", 0, 0, 0, 6);
    chk_rd("cont_newest", 0, 1023, 0, 1029);
    chk_rd("cont_newest_q", 1, 1023, 0, -1029);
    chk_rd("cont_offset", 0, 0, 2, 8);

    // re-arm mid-fill coinciding with a strobe
    arm_cap(1'b0, 0);
    for (int k = 0; k < 500; k++) strobe((k == 10) ? 'h7FFFFF : k + 1, 0);
    settle();
    check("rearm_pre_sat", 32'(sat_cnt), 1);
    arm = 1'b1; continuous = 1'b0; shift = '0;
    in_strobe = 1'b1; in_i = 24'h001234; in_q = 24'h001234;
    tick();
    arm = 1'b0; in_strobe = 1'b0;
    check("rearm_wr_ptr", 32'(wr_ptr), 0);
    check("rearm_sat", 32'(sat_cnt), 0);
    check("rearm_busy", 32'(busy), 1);
    settle();
    check("rearm_dropped_ptr", 32'(wr_ptr), 0);
    chk_rd("rearm_addr0_old", 0, 0, 0, 1);
    strobe('h55, 'h66);
    settle();
    check("rearm_next_ptr", 32'(wr_ptr), 1);
    chk_rd("rearm_next_i", 0, 0, 0, 'h55);
    chk_rd("rearm_next_q", 1, 0, 0, 'h66);
    chk_rd("rearm_addr1_old", 0, 1, 0, 2);

    // async reset mid-ring
    arm_cap(1'b1, 0);
    for (int k = 0; k < 50; k++) strobe(k + 100, 0);
    strobe('h7FFFFF, 0);
    settle();
    check("rstc_sat", 32'(sat_cnt), 1);
    chk_rd("rstc_newest", 0, 1023, 0, 'h7FFF);
    in_strobe = 1'b1; in_i = 24'h000999; in_q = 24'h000999;
    #2; rst_n = 1'b0; #1;
    check("rstc_busy", 32'(busy), 0);
    check("rstc_done", 32'(done), 0);
    check("rstc_wr_ptr", 32'(wr_ptr), 0);
    check("rstc_sat0", 32'(sat_cnt), 0);
    check("rstc_rd_valid", 32'(rd_valid), 0);
    check("rstc_rd_data", 32'(rd_data), 0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    in_strobe = 1'b0;
    settle();
    check("rstc_idle_ptr", 32'(wr_ptr), 0);
    check("rstc_idle_busy", 32'(busy), 0);
    chk_rd("rstc_no_write", 0, 0, 0, 100);

    // random one-shot vs model
    for (int pass = 0; pass < 2; pass++) begin
      sh = $urandom_range(0, 8);
      arm_cap(1'b0, sh);
      exp_sat = 0;
      for (int k = 0; k < DEPTH; k++) begin
        if ($urandom_range(0, 3) == 0) tick();
        vi = rand24(); vq = rand24();
        mi[k] = ref_clamp(ref_scale(vi, sh));
        mq[k] = ref_clamp(ref_scale(vq, sh));
        if (mi[k] != ref_scale(vi, sh) || mq[k] != ref_scale(vq, sh)) exp_sat++;
        strobe(vi, vq);
      end
      settle();
      check("rnd_os_done", 32'(done), 1);
      check("rnd_os_sat", 32'(sat_cnt), exp_sat);
      for (int r = 0; r < 24; r++) begin
        a = $urandom_range(0, DEPTH - 1); off = $urandom_range(0, DEPTH - 1);
        phys = (a + off) % DEPTH;
        if (r[0]) chk_rd("rnd_os_q", 1, a, off, mq[phys]);
        else      chk_rd("rnd_os_i", 0, a, off, mi[phys]);
      end
    end

    // random ring vs model
    sh = $urandom_range(0, 8);
    arm_cap(1'b1, sh);
    n = $urandom_range(1100, 1500);
    for (int k = 0; k < n; k++) begin
      vi = rand24(); vq = rand24();
      mi[k % DEPTH] = ref_clamp(ref_scale(vi, sh));
      mq[k % DEPTH] = ref_clamp(ref_scale(vq, sh));
      strobe(vi, vq);
    end
    settle();
    check("rnd_cont_wr_ptr", 32'(wr_ptr), n % DEPTH);
    for (int r = 0; r < 24; r++) begin
      a = $urandom_range(0, DEPTH - 1); off = $urandom_range(0, DEPTH - 1);
      phys = (n + a + off) % DEPTH;
      if (r[0]) chk_rd("rnd_cont_q", 1, a, off, mq[phys]);
      else      chk_rd("rnd_cont_i", 0, a, off, mi[phys]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
